led_bar_sequencer: RTL and testbench

//   Controller that owns the 6-LED bar and sequences display patterns on it:
//   OFF, bounce-scan, fill/drain and blink. It generates its own step timebase

---
 rtl/led_bar_sequencer_if.sv | 24 ++
 rtl/led_bar_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_led_bar_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_bar_sequencer_if.sv
// Mode-request handshake between the user-input logic and the LED bar
// sequencer.
//   mode_req_valid  requester -> sequencer  a mode change is being offered
//   mode_req_id     requester -> sequencer  0=OFF 1=SCAN 2=FILL 3=BLINK
//   mode_req_ready  sequencer -> requester  high = offer taken on this edge
// master = requester side, slave = sequencer side.
`timescale 1ns/1ps
interface led_bar_sequencer_if;
    logic       mode_req_valid;
    logic [1:0] mode_req_id;
    logic       mode_req_ready;

    modport master (
        output mode_req_valid,
        output mode_req_id,
        input  mode_req_ready
    );

    modport slave (
        input  mode_req_valid,
        input  mode_req_id,
        output mode_req_ready
    );
endinterface

// File: rtl/led_bar_sequencer.sv
// LED bar sequencer: owns an N_LEDS-wide LED bar and plays OFF, bounce-scan,
// fill/drain and blink patterns on it. A free-running prescaler derives the
// pattern step timebase from clk. Mode changes arrive over a valid/ready
// handshake. They are parked in a one-deep pending register and take effect
// only on a step boundary, so a frame is never cut short.
//
// Ports
//   clk        system clock
//   rst_n      synchronous reset, active-low
//   req        mode request handshake (slave side)
//   speed_sel  step period = STEP_DIV >> speed_sel, sampled at each step wrap
//   pause      freezes prescaler, pattern position and LEDs
//   mode_cur   mode currently being displayed
//   step_tick  one-cycle pulse in the last clock of every pattern step
//   led        LED drive, active-low (0 = lit)
`timescale 1ns/1ps
module led_bar_sequencer #(
    parameter int CLK_HZ      = 27000000,
    parameter int STEP_DIV    = 1687500,
    parameter int N_LEDS      = 6,
    parameter int BLINK_STEPS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    led_bar_sequencer_if.slave    req,
    input  logic [1:0]            speed_sel,
    input  logic                  pause,
    output logic [1:0]            mode_cur,
    output logic                  step_tick,
    output logic [N_LEDS-1:0]     led
);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int PW = $clog2(N_LEDS + 1);
    localparam int BW = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;
    localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);

    // CLK_HZ only documents where STEP_DIV came from; catch nonsense values.
    if (CLK_HZ <= 0 || STEP_DIV < 1 || N_LEDS < 2 || BLINK_STEPS < 1) begin : g_bad_params
        $error("led_bar_sequencer: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_OFF,
        S_SCAN_UP,
        S_SCAN_DN,
        S_FILL_UP,
        S_FILL_DN,
        S_BLINK_ON,
        S_BLINK_OFF
    } state_t;

    logic [CW-1:0]     cnt_reg;
    logic [CW-1:0]     period_m1_reg;
    state_t            state_reg;
    logic [PW-1:0]     pos_reg;
    logic [BW-1:0]     blink_reg;
    logic              pend_valid_reg;
    logic [1:0]        pend_id_reg;
    logic [1:0]        mode_reg;
    logic [N_LEDS-1:0] led_reg;
    logic              tick;

    // Step length minus one for a given speed; a zero-length step becomes one.
    function automatic logic [CW-1:0] period_m1_of(input logic [1:0] s);
        int t;
        t = STEP_DIV >> s;
        if (t < 1) begin
            t = 1;
        end
        return CW'(t - 1);
    endfunction

    function automatic logic [N_LEDS-1:0] scan_led(input logic [PW-1:0] p);
        return ~(ONE << p);
    endfunction

    // p lit LEDs from bit 0; p = N_LEDS wraps the shift to 0 and gives all lit.
    function automatic logic [N_LEDS-1:0] fill_led(input logic [PW-1:0] p);
        return ~((ONE << p) - ONE);
    endfunction

    // Gated by rst_n so no tick is ever shown while reset is held.
    assign tick = rst_n && !pause && (cnt_reg == period_m1_reg);

    // Prescaler. The period is re-sampled only at the wrap, so a speed change
    // always lets the step in progress run to its full length.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            period_m1_reg <= period_m1_of(speed_sel);
        end else if (!pause) begin
            if (cnt_reg == period_m1_reg) begin
                cnt_reg       <= '0;
                period_m1_reg <= period_m1_of(speed_sel);
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Pattern FSM plus request handshake. A request accepted in a tick cycle
    // lands in pending after this tick has been used, so it waits for the next.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_OFF;
            pos_reg        <= '0;
            blink_reg      <= '0;
            pend_valid_reg <= 1'b0;
            pend_id_reg    <= '0;
            mode_reg       <= '0;
            led_reg        <= '1;
        end else begin
            if (tick && pend_valid_reg) begin
                pend_valid_reg <= 1'b0;
                mode_reg       <= pend_id_reg;
                pos_reg        <= '0;
                blink_reg      <= '0;
                case (pend_id_reg)
                    2'd1: begin
                        state_reg <= S_SCAN_UP;
                        led_reg   <= scan_led(PW'(0));
                    end
                    2'd2: begin
                        state_reg <= S_FILL_UP;
                        led_reg   <= fill_led(PW'(0));
                    end
                    2'd3: begin
                        state_reg <= S_BLINK_ON;
                        led_reg   <= '0;
                    end
                    default: begin
                        state_reg <= S_OFF;
                        led_reg   <= '1;
                    end
                endcase
            end else if (tick) begin
                case (state_reg)
                    // Direction flips on reaching an end so the endpoint is
                    // shown once, not twice.
                    S_SCAN_UP: begin
                        pos_reg <= pos_reg + 1'b1;
                        led_reg <= scan_led(pos_reg + 1'b1);
                        if (pos_reg == PW'(N_LEDS - 2)) begin
                            state_reg <= S_SCAN_DN;
                        end
                    end
                    S_SCAN_DN: begin
                        pos_reg <= pos_reg - 1'b1;
                        led_reg <= scan_led(pos_reg - 1'b1);
                        if (pos_reg == PW'(1)) begin
                            state_reg <= S_SCAN_UP;
                        end
                    end
                    S_FILL_UP: begin
                        pos_reg <= pos_reg + 1'b1;
                        led_reg <= fill_led(pos_reg + 1'b1);
                        if (pos_reg == PW'(N_LEDS - 1)) begin
                            state_reg <= S_FILL_DN;
                        end
                    end
                    S_FILL_DN: begin
                        pos_reg <= pos_reg - 1'b1;
                        led_reg <= fill_led(pos_reg - 1'b1);
                        if (pos_reg == PW'(1)) begin
                            state_reg <= S_FILL_UP;
                        end
                    end
                    S_BLINK_ON: begin
                        if (blink_reg == BW'(BLINK_STEPS - 1)) begin
                            blink_reg <= '0;
                            state_reg <= S_BLINK_OFF;
                            led_reg   <= '1;
                        end else begin
                            blink_reg <= blink_reg + 1'b1;
                        end
                    end
                    S_BLINK_OFF: begin
                        if (blink_reg == BW'(BLINK_STEPS - 1)) begin
                            blink_reg <= '0;
                            state_reg <= S_BLINK_ON;
                            led_reg   <= '0;
                        end else begin
                            blink_reg <= blink_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= S_OFF;
                        led_reg   <= '1;
                    end
                endcase
            end

            // Only ever true while nothing is pending, so it cannot collide
            // with the apply branch above.
            if (req.mode_req_valid && !pend_valid_reg) begin
                pend_valid_reg <= 1'b1;
                pend_id_reg    <= req.mode_req_id;
            end
        end
    end

    assign req.mode_req_ready = ~pend_valid_reg;
    assign mode_cur           = mode_reg;
    assign step_tick          = tick;
    assign led                = led_reg;
endmodule

// File: tb/tb_led_bar_sequencer.sv
`timescale 1ns/1ps
module tb_led_bar_sequencer;
    localparam int STEP_DIV = 4;
    localparam int N        = 6;
    localparam int BS       = 2;
    localparam int WAIT_MAX = 100;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic [1:0]   speed_sel = 2'd0;
    logic         pause     = 1'b0;
    logic [1:0]   mode_cur;
    logic         step_tick;
    logic [N-1:0] led;

    led_bar_sequencer_if req_if();

    led_bar_sequencer #(
        .CLK_HZ      (27000000),
        .STEP_DIV    (STEP_DIV),
        .N_LEDS      (N),
        .BLINK_STEPS (BS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_if),
        .speed_sel (speed_sel),
        .pause     (pause),
        .mode_cur  (mode_cur),
        .step_tick (step_tick),
        .led       (led)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state: step counter within the mode, not FSM states.
    int m_cnt     = 0;
    int m_t       = 1;
    int m_mode    = 0;
    int m_idx     = 0;
    int m_pend_id = 0;
    bit m_pend_v  = 1'b0;
    bit started   = 1'b0;

    typedef struct {
        int           cyc;
        int           mode;
        logic [N-1:0] led;
    } tick_t;
    tick_t sb_q[$];

    function automatic int tval(input logic [1:0] s);
        int t;
        t = STEP_DIV >> s;
        return (t < 1) ? 1 : t;
    endfunction

    // Expected led for step number idx of a mode, from the pattern rules.
    function automatic logic [N-1:0] pattern_led(input int mode, input int idx);
        int m;
        int p;
        logic [N-1:0] lit;
        lit = '0;
        case (mode)
            1: begin
                m = idx % (2 * N - 2);
                p = (m < N) ? m : (2 * N - 2) - m;
                lit[p] = 1'b1;
            end
            2: begin
                m = idx % (2 * N);
                p = (m <= N) ? m : (2 * N) - m;
                for (int b = 0; b < N; b++) begin
                    if (b < p) lit[b] = 1'b1;
                end
            end
            3: lit = (((idx / BS) % 2) == 0) ? '1 : '0;
            default: lit = '0;
        endcase
        return ~lit;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Model: evaluated on each rising edge using the inputs the DUT sees.
    initial begin
        bit tk;
        bit acc;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_cnt    = 0;
                m_t      = tval(speed_sel);
                m_pend_v = 1'b0;
                m_mode   = 0;
                m_idx    = 0;
                started  = 1'b1;
            end else if (started) begin
                tk  = (m_cnt == m_t - 1) && !pause;
                acc = req_if.mode_req_valid && !m_pend_v;
                if (!pause) begin
                    if (m_cnt == m_t - 1) begin
                        m_cnt = 0;
                        m_t   = tval(speed_sel);
                    end else begin
                        m_cnt++;
                    end
                end
                if (tk) begin
                    if (m_pend_v) begin
                        m_mode   = m_pend_id;
                        m_idx    = 0;
                        m_pend_v = 1'b0;
                    end else begin
                        m_idx++;
                    end
                    sb_q.push_back('{cyc, m_mode, pattern_led(m_mode, m_idx)});
                end
                if (acc) begin
                    m_pend_v  = 1'b1;
                    m_pend_id = int'(req_if.mode_req_id);
                end
            end
            cyc++;
        end
    end

    // Monitor: samples on the falling edge. A tick seen here is matched to
    // the scoreboard entry once the following edge has updated the LEDs.
    initial begin
        bit    tick_prev = 1'b0;
        int    tick_cyc  = 0;
        tick_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                if (tick_prev) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tick_unexpected cyc=%0d actual=tick expected=no_tick", tick_cyc);
                    end else begin
                        e = sb_q.pop_front();
                        check("tick_cycle", tick_cyc, e.cyc);
                        check("tick_led", int'(led), int'(e.led));
                        check("tick_mode", int'(mode_cur), e.mode);
                        $display("tick cyc=%0d mode=%0d led=%b", tick_cyc, mode_cur, led);
                    end
                end
                check("led", int'(led), int'(pattern_led(m_mode, m_idx)));
                check("mode_cur", int'(mode_cur), m_mode);
                check("mode_req_ready", int'(req_if.mode_req_ready), int'(!m_pend_v));
                check("step_tick", int'(step_tick),
                      int'(rst_n && !pause && (m_cnt == m_t - 1)));
                tick_prev = step_tick;
                tick_cyc  = cyc;
            end
        end
    end

    // Stimulus helpers: every task starts and ends 1 ns after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_req(input int id);
        int n;
        n = 0;
        req_if.mode_req_valid = 1'b1;
        req_if.mode_req_id    = 2'(id);
        @(negedge clk);
        while (!req_if.mode_req_ready && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        check("req_accept_in_time", int'(n < WAIT_MAX), 1);
        @(posedge clk);
        #1;
        req_if.mode_req_valid = 1'b0;
        $display("req id=%0d accepted cyc=%0d", id, cyc);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_if.mode_req_ready && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        check("apply_in_time", int'(n < WAIT_MAX), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int k);
        int n;
        int seen;
        n    = 0;
        seen = 0;
        while (seen < k && n < WAIT_MAX) begin
            @(negedge clk);
            if (step_tick) seen++;
            n++;
        end
        check("ticks_in_time", int'(seen == k), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        req_if.mode_req_valid = 1'b0;
        req_if.mode_req_id    = 2'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);

        // Scan sweep.
        send_req(1);
        idle(44);

        // FILL then BLINK back to back; BLINK stays offered until FILL applies.
        send_req(2);
        send_req(3);
        wait_ready();
        idle(70);

        // Speed change in the middle of a step.
        idle(1);
        speed_sel = 2'd3;
        idle(30);
        speed_sel = 2'd0;
        idle(8);

        // Pause during scan at position 3.
        send_req(1);
        wait_ready();
        wait_ticks(3);
        pause = 1'b1;
        idle(10);
        pause = 1'b0;
        idle(12);

        // Reset with FILL at k=4 and a request still pending.
        send_req(2);
        wait_ready();
        wait_ticks(4);
        send_req(3);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(20);

        // Randomised mix of requests, speed changes, pauses and resets.
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40) begin
                pause = 1'b0;
                send_req(int'($urandom_range(0, 3)));
            end else if (r < 55) begin
                speed_sel = 2'($urandom_range(0, 3));
            end else if (r < 75) begin
                pause = 1'b1;
                idle(int'($urandom_range(1, 6)));
                pause = 1'b0;
            end else if (r < 78) begin
                rst_n = 1'b0;
                idle(1);
                rst_n = 1'b1;
            end
            idle(int'($urandom_range(1, 25)));
        end

        pause = 1'b0;
        idle(10);
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
